// File: rtl/rv_pkg.sv
// Shared constants for the integer register file and write-back stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rv_pkg;
    localparam int XLEN = 64;
    localparam int NREG = 32;
    localparam int AW   = 5;

    localparam logic [AW-1:0] REG_ZERO = '0;
endpackage

// File: rtl/writeback_regfile_if.sv
// MEM/WB, decode read, forwarding and debug signals of the write-back stage.
// Latency: n/a (wiring bundle).
// Backpressure: none; upstream inserts bubbles instead of stalling.
interface writeback_regfile_if;
    import rv_pkg::*;

    logic            mem_wb_valid;
    logic [AW-1:0]   mem_wb_rd;
    logic            mem_wb_RegWrite;
    logic            mem_wb_MemtoReg;
    logic [XLEN-1:0] mem_wb_alu_result;
    logic [XLEN-1:0] mem_wb_mem_data;
    logic [AW-1:0]   id_rs1;
    logic [AW-1:0]   id_rs2;
    logic [XLEN-1:0] id_rs1_data;
    logic [XLEN-1:0] id_rs2_data;
    logic [XLEN-1:0] wb_data;
    logic [AW-1:0]   fwd_rd;
    logic            fwd_RegWrite;
    logic [XLEN-1:0] fwd_data;
    logic [63:0]     retire_count;
    logic [AW-1:0]   dbg_addr;
    logic [XLEN-1:0] dbg_data;

    // Pipeline / testbench side
    modport master (
        output mem_wb_valid, mem_wb_rd, mem_wb_RegWrite, mem_wb_MemtoReg,
               mem_wb_alu_result, mem_wb_mem_data, id_rs1, id_rs2, dbg_addr,
        input  id_rs1_data, id_rs2_data, wb_data, fwd_rd, fwd_RegWrite,
               fwd_data, retire_count, dbg_data
    );

    // Write-back stage side
    modport slave (
        input  mem_wb_valid, mem_wb_rd, mem_wb_RegWrite, mem_wb_MemtoReg,
               mem_wb_alu_result, mem_wb_mem_data, id_rs1, id_rs2, dbg_addr,
        output id_rs1_data, id_rs2_data, wb_data, fwd_rd, fwd_RegWrite,
               fwd_data, retire_count, dbg_data
    );
endinterface

// File: rtl/regfile_2r1w.sv
// 32x64 register array: two raw combinational read ports, one debug read, one write.
// Latency: reads combinational; a write is visible on reads the cycle after commit.
// Backpressure: none; the write enable is taken as-is every cycle.
module regfile_2r1w
    import rv_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            i_we,
    input  logic [AW-1:0]   i_waddr,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [AW-1:0]   i_raddr1,
    input  logic [AW-1:0]   i_raddr2,
    input  logic [AW-1:0]   i_dbg_addr,
    output logic [XLEN-1:0] o_rdata1,
    output logic [XLEN-1:0] o_rdata2,
    output logic [XLEN-1:0] o_dbg_data
);
    logic [XLEN-1:0] r_regs [NREG];

    // Array write; x0 is never written so it stays zero after reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we && (i_waddr != REG_ZERO)) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    // x0 is forced to zero on read as well, independent of array contents
    assign o_rdata1   = (i_raddr1   == REG_ZERO) ? '0 : r_regs[i_raddr1];
    assign o_rdata2   = (i_raddr2   == REG_ZERO) ? '0 : r_regs[i_raddr2];
    assign o_dbg_data = (i_dbg_addr == REG_ZERO) ? '0 : r_regs[i_dbg_addr];
endmodule

// File: rtl/writeback_regfile.sv
// Write-back select, register commit with write-first read bypass, WB forwarding and retire count.
// Latency: wb_data/read ports combinational; fwd_* and retire_count one cycle after MEM/WB.
// Backpressure: none; stalls arrive as MEM/WB bubbles (valid low).
module writeback_regfile
    import rv_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    writeback_regfile_if.slave  bus
);
    logic [XLEN-1:0] w_wb_data;
    logic            w_commit;
    logic [XLEN-1:0] w_rf_rdata1;
    logic [XLEN-1:0] w_rf_rdata2;

    logic [AW-1:0]   r_fwd_rd;
    logic            r_fwd_regwrite;
    logic [XLEN-1:0] r_fwd_data;
    logic [63:0]     r_retire_count;

    assign w_wb_data = bus.mem_wb_MemtoReg ? bus.mem_wb_mem_data : bus.mem_wb_alu_result;
    assign w_commit  = bus.mem_wb_valid & bus.mem_wb_RegWrite & (bus.mem_wb_rd != REG_ZERO);

    regfile_2r1w u_rf (
        .clk        (clk),
        .reset      (reset),
        .i_we       (w_commit),
        .i_waddr    (bus.mem_wb_rd),
        .i_wdata    (w_wb_data),
        .i_raddr1   (bus.id_rs1),
        .i_raddr2   (bus.id_rs2),
        .i_dbg_addr (bus.dbg_addr),
        .o_rdata1   (w_rf_rdata1),
        .o_rdata2   (w_rf_rdata2),
        .o_dbg_data (bus.dbg_data)
    );

    // Write-first bypass: x0 wins, then the in-flight commit, then the array
    always_comb begin
        bus.id_rs1_data = w_rf_rdata1;
        bus.id_rs2_data = w_rf_rdata2;
        if (bus.id_rs1 == REG_ZERO) begin
            bus.id_rs1_data = '0;
        end else if (w_commit && (bus.mem_wb_rd == bus.id_rs1)) begin
            bus.id_rs1_data = w_wb_data;
        end
        if (bus.id_rs2 == REG_ZERO) begin
            bus.id_rs2_data = '0;
        end else if (w_commit && (bus.mem_wb_rd == bus.id_rs2)) begin
            bus.id_rs2_data = w_wb_data;
        end
    end

    // Forwarding bundle mirrors the last commit; zeroed when nothing commits
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fwd_regwrite <= 1'b0;
            r_fwd_rd       <= '0;
            r_fwd_data     <= '0;
        end else begin
            r_fwd_regwrite <= w_commit;
            r_fwd_rd       <= w_commit ? bus.mem_wb_rd : REG_ZERO;
            r_fwd_data     <= w_commit ? w_wb_data : '0;
        end
    end

    // Every valid instruction retires, including stores and branches; wraps naturally
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_retire_count <= '0;
        end else if (bus.mem_wb_valid) begin
            r_retire_count <= r_retire_count + 64'd1;
        end
    end

    assign bus.wb_data      = w_wb_data;
    assign bus.fwd_rd       = r_fwd_rd;
    assign bus.fwd_RegWrite = r_fwd_regwrite;
    assign bus.fwd_data     = r_fwd_data;
    assign bus.retire_count = r_retire_count;
endmodule

// File: tb/tb_writeback_regfile.sv
// Directed bench for writeback_regfile: reset, commit/bypass, x0, bubbles, async reset, wrap.
// Latency: checks combinational outputs #1 after input change, registered ones #1 after posedge.
// Backpressure: n/a.
module tb_writeback_regfile;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;

    writeback_regfile_if bus ();

    writeback_regfile dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic rw, input logic m2r, input logic [4:0] rd,
                         input logic [63:0] alu, input logic [63:0] mem);
        bus.mem_wb_valid      = v;
        bus.mem_wb_RegWrite   = rw;
        bus.mem_wb_MemtoReg   = m2r;
        bus.mem_wb_rd         = rd;
        bus.mem_wb_alu_result = alu;
        bus.mem_wb_mem_data   = mem;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 5'd0, 64'd0, 64'd0);
        bus.id_rs1   = 5'd0;
        bus.id_rs2   = 5'd0;
        bus.dbg_addr = 5'd0;

        // Reset state
        #12;
        check("rst_fwd_we", {63'd0, bus.fwd_RegWrite}, 64'd0);
        check("rst_retire", bus.retire_count, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            bus.dbg_addr = i[4:0];
            #1;
            check($sformatf("rst_dbg%0d", i), bus.dbg_data, 64'd0);
        end
        check("rst_fwd_rd", {59'd0, bus.fwd_rd}, 64'd0);
        check("rst_fwd_data", bus.fwd_data, 64'd0);

        // ALU write to x5 with same-cycle bypass
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 5'd5, 64'h1234, 64'hDEAD);
        bus.id_rs1   = 5'd5;
        bus.id_rs2   = 5'd0;
        bus.dbg_addr = 5'd5;
        #1;
        check("byp_rs1", bus.id_rs1_data, 64'h1234);
        check("byp_rs2_x0", bus.id_rs2_data, 64'd0);
        check("wb_alu", bus.wb_data, 64'h1234);
        check("dbg_nobyp", bus.dbg_data, 64'd0);
        @(posedge clk); #1;
        check("x5_dbg", bus.dbg_data, 64'h1234);
        check("x5_fwd_rd", {59'd0, bus.fwd_rd}, 64'd5);
        check("x5_fwd_data", bus.fwd_data, 64'h1234);
        check("x5_fwd_we", {63'd0, bus.fwd_RegWrite}, 64'd1);
        check("x5_retire", bus.retire_count, 64'd1);

        // Load data to x7
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 5'd7, 64'd2, 64'd90);
        bus.id_rs1   = 5'd7;
        bus.dbg_addr = 5'd7;
        #1;
        check("wb_mem", bus.wb_data, 64'd90);
        check("x7_byp", bus.id_rs1_data, 64'd90);
        @(posedge clk); #1;
        check("x7_dbg", bus.dbg_data, 64'd90);
        check("x7_retire", bus.retire_count, 64'd2);

        // Write to x0 is dropped but still retires
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 5'd0, 64'd55, 64'd0);
        bus.id_rs1   = 5'd0;
        bus.dbg_addr = 5'd0;
        #1;
        check("x0_rs1", bus.id_rs1_data, 64'd0);
        check("x0_wb", bus.wb_data, 64'd55);
        @(posedge clk); #1;
        check("x0_fwd_we", {63'd0, bus.fwd_RegWrite}, 64'd0);
        check("x0_fwd_rd", {59'd0, bus.fwd_rd}, 64'd0);
        check("x0_fwd_data", bus.fwd_data, 64'd0);
        check("x0_dbg", bus.dbg_data, 64'd0);
        check("x0_retire", bus.retire_count, 64'd3);

        // rs1 == rs2 == rd: both ports bypass
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 5'd12, 64'hABC, 64'h1);
        bus.id_rs1 = 5'd12;
        bus.id_rs2 = 5'd12;
        #1;
        check("dual_rs1", bus.id_rs1_data, 64'hABC);
        check("dual_rs2", bus.id_rs2_data, 64'hABC);
        @(posedge clk); #1;
        check("dual_retire", bus.retire_count, 64'd4);

        // Bubble with RegWrite set: nothing happens
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 5'd9, 64'd77, 64'd0);
        bus.id_rs1   = 5'd9;
        bus.id_rs2   = 5'd7;
        bus.dbg_addr = 5'd9;
        #1;
        check("bub_rs1", bus.id_rs1_data, 64'd0);
        check("bub_rs2_arr", bus.id_rs2_data, 64'd90);
        @(posedge clk); #1;
        check("bub_dbg", bus.dbg_data, 64'd0);
        check("bub_retire", bus.retire_count, 64'd4);
        check("bub_fwd_we", {63'd0, bus.fwd_RegWrite}, 64'd0);

        // Write x3=10, then asynchronous reset mid-cycle
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 5'd3, 64'd10, 64'd0);
        bus.dbg_addr = 5'd3;
        bus.id_rs1   = 5'd3;
        bus.id_rs2   = 5'd0;
        @(posedge clk); #1;
        check("x3_dbg", bus.dbg_data, 64'd10);
        check("x3_fwd_rd", {59'd0, bus.fwd_rd}, 64'd3);
        check("x3_retire", bus.retire_count, 64'd5);
        drive(1'b0, 1'b0, 1'b0, 5'd0, 64'd0, 64'd0);
        #2;
        reset = 1'b1;
        #1;
        check("arst_dbg3", bus.dbg_data, 64'd0);
        check("arst_rs1", bus.id_rs1_data, 64'd0);
        check("arst_fwd_we", {63'd0, bus.fwd_RegWrite}, 64'd0);
        check("arst_fwd_rd", {59'd0, bus.fwd_rd}, 64'd0);
        check("arst_fwd_data", bus.fwd_data, 64'd0);
        check("arst_retire", bus.retire_count, 64'd0);

        // Commit during reset is lost
        drive(1'b1, 1'b1, 1'b0, 5'd3, 64'd99, 64'd0);
        @(posedge clk); #1;
        check("inrst_dbg3", bus.dbg_data, 64'd0);
        check("inrst_retire", bus.retire_count, 64'd0);

        // First commit after release
        @(negedge clk);
        reset = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 5'd3, 64'd6, 64'd0);
        @(posedge clk); #1;
        check("post_dbg3", bus.dbg_data, 64'd6);
        check("post_fwd_data", bus.fwd_data, 64'd6);
        check("post_retire", bus.retire_count, 64'd1);

        // Counter wrap from all-ones; a store (RegWrite=0) still retires
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 5'd0, 64'd0, 64'd0);
        dut.r_retire_count = '1;
        #1;
        check("wrap_pre", bus.retire_count, 64'hFFFF_FFFF_FFFF_FFFF);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 5'd4, 64'd1, 64'd0);
        @(posedge clk); #1;
        check("wrap_zero", bus.retire_count, 64'd0);
        check("store_fwd_we", {63'd0, bus.fwd_RegWrite}, 64'd0);
        @(posedge clk); #1;
        check("wrap_one", bus.retire_count, 64'd1);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 5'd0, 64'd0, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/writeback_regfile.md
Name: writeback_regfile

Overview:
Write-back stage plus integer register file for the 5-stage RISC-V pipeline. It consumes the MEM/WB pipeline register driven by the memory stage and selects load data or ALU result. It commits the selected value to the 32x64 register file and serves the two decode-stage read ports with same-cycle write bypass. It also drives a registered WB forwarding bundle for the hazard/forwarding unit and a retired-instruction counter.

Parameters:
XLEN, 64, datapath and register width
NREG, 32, number of architectural registers (x0 hardwired zero)
AW, 5, register index width (log2 NREG)

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous active-high reset
mem_wb_valid  in  1  MEM/WB holds a real instruction (0 = bubble)
mem_wb_rd  in  AW  destination register index
mem_wb_RegWrite  in  1  instruction writes rd
mem_wb_MemtoReg  in  1  1 = write load data, 0 = write ALU result
mem_wb_alu_result  in  XLEN  ALU result from MEM/WB
mem_wb_mem_data  in  XLEN  load data from MEM/WB
id_rs1  in  AW  decode read index 1
id_rs2  in  AW  decode read index 2
id_rs1_data  out  XLEN  read data 1 (combinational, bypassed)
id_rs2_data  out  XLEN  read data 2 (combinational, bypassed)
wb_data  out  XLEN  selected write-back value (combinational)
fwd_rd  out  AW  registered rd of the last committed write
fwd_RegWrite  out  1  registered: fwd_rd/fwd_data are valid
fwd_data  out  XLEN  registered value of the last committed write
retire_count  out  64  instructions retired since reset
dbg_addr  in  AW  debug read index
dbg_data  out  XLEN  debug read data, raw array, no bypass

Behaviour:
- Clock is clk. Reset is asynchronous and active-high, named reset.
- wb_data = mem_wb_MemtoReg ? mem_wb_mem_data : mem_wb_alu_result. It is pure combinational and computed regardless of valid.
- commit = mem_wb_valid & mem_wb_RegWrite & (mem_wb_rd != 0).
- Posedge clk with commit: regs[mem_wb_rd] <= wb_data. With no commit, the array holds.
- x0 always reads 0. Writes to x0 are dropped and never update fwd_*.
- Read ports, evaluated in this priority order:
  - (rs == 0) -> 0
  - else if commit & (mem_wb_rd == rs) -> wb_data (write-first bypass, same cycle)
  - else -> regs[rs]
- rs1 == rs2 == rd in the same cycle: both ports return wb_data.
- dbg_data = regs[dbg_addr], or 0 for index 0. There is no bypass, so a write is visible the cycle after commit.
- Forwarding bundle, registered every posedge:
  - fwd_RegWrite <= commit
  - fwd_rd <= commit ? mem_wb_rd : 0
  - fwd_data <= commit ? wb_data : 0
  - One-cycle latency from MEM/WB to fwd_*.
- retire_count increments by 1 on each posedge with mem_wb_valid = 1. This includes stores and branches (RegWrite = 0). It wraps modulo 2^64 from all-ones to 0.
- Bubble (mem_wb_valid = 0) with RegWrite = 1: no write, no count, fwd_RegWrite <= 0.
- Reset (any time, including mid-write):
  - all regs = 0, fwd_rd = 0, fwd_RegWrite = 0, fwd_data = 0, retire_count = 0
  - A commit coincident with reset assertion is lost.
  - The first commit occurs at the first posedge after reset deasserts.
- No stall input. The upstream stage holds MEM/WB as a bubble when the pipeline stalls.

Decomposition:
- Shared package rv_pkg holds:
  - XLEN, NREG, AW constants
  - REG_ZERO = 0
- One natural sub-module, regfile_2r1w:
  - 2 combinational read ports plus 1 raw debug read port, 1 synchronous write port
  - async reset clear, x0 hardwired
- The top level adds write-back mux, bypass, forwarding register and retire counter.

Test Plan:
- Reset, then read all 32 indices via dbg_addr -> every dbg_data = 0; fwd_RegWrite = 0; retire_count = 0.
- valid=1, RegWrite=1, MemtoReg=0, rd=5, alu=0x1234, mem_data=0xDEAD; id_rs1=5 same cycle:
  - id_rs1_data = 0x1234 (bypass)
  - next cycle: dbg_addr=5 -> 0x1234; fwd_rd=5, fwd_data=0x1234, fwd_RegWrite=1; retire_count=1
- MemtoReg=1, rd=7, mem_data=90, alu=2 -> regs[7] = 90. Next: rd=0, RegWrite=1, alu=55 -> id_rs1=0 reads 0, fwd_RegWrite=0, retire_count still increments.
- Bubble, valid=0, RegWrite=1, rd=9, alu=77 -> regs[9] unchanged (0), retire_count unchanged, fwd_RegWrite=0.
- Assert reset asynchronously mid-cycle after writing x3=10:
  - outputs clear immediately without a clock edge; regs[3] = 0
  - write x3=6 after release -> dbg reads 6
- Force retire_count to all-ones (preload via 2^64-1 valid cycles, or hierarchical deposit), one valid cycle -> retire_count = 0.
